// File: rtl/trapez_energy_picker.sv
// rtl/trapez_energy_picker.sv - trapezoid flat-top energy picker
//
// Watches one channel of trapezoidal shaper output. A valid sample above
// threshold (after the input has been seen at or below threshold) triggers an
// event. The next RISE_TIME valid samples are skipped, the following
// FLAT_SAMPLES valid samples are summed, and the sum is emitted as one energy
// word tagged with the sample count of the trigger sample.
//
// Optional feature macro: TRAPEZ_PILEUP_REJECT_EN
//   When defined, a dip to or below threshold during RISE or FLAT aborts the
//   event and bumps a saturating pileup counter.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous, active-high reset
//   data_in_i       signed shaper sample
//   data_in_valid_i sample strobe; only valid samples advance any state
//   threshold_i     signed trigger level, compared on each valid sample
//   energy_o        signed flat-top sum, held between pulses
//   energy_valid_o  one-clock pulse qualifying energy_o / timestamp_o
//   timestamp_o     sample count latched at the trigger sample
//   busy_o          high while an event is in progress (RISE, FLAT, FALL)
//   pileup_count_o  rejected-event counter (0 without the optional feature)

module trapez_energy_picker #(
  parameter int SIZE_DATA    = 26,
  parameter int RISE_TIME    = 25,
  parameter int FLAT_SAMPLES = 20,
  parameter int SIZE_ENERGY  = SIZE_DATA + 8,
  parameter int SIZE_TIME    = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [SIZE_DATA-1:0]   data_in_i,
  input  logic                   data_in_valid_i,
  input  logic [SIZE_DATA-1:0]   threshold_i,
  output logic [SIZE_ENERGY-1:0] energy_o,
  output logic                   energy_valid_o,
  output logic [SIZE_TIME-1:0]   timestamp_o,
  output logic                   busy_o,
  output logic [15:0]            pileup_count_o
);

  // Phase counter only needs to reach the larger of the two phase lengths.
  localparam int PHASE_MAX = (RISE_TIME > FLAT_SAMPLES) ? RISE_TIME : FLAT_SAMPLES;
  localparam int PHASE_W   = (PHASE_MAX < 2) ? 1 : $clog2(PHASE_MAX);
  localparam logic [PHASE_W-1:0] RISE_LAST = PHASE_W'((RISE_TIME > 0) ? RISE_TIME - 1 : 0);
  localparam logic [PHASE_W-1:0] FLAT_LAST = PHASE_W'(FLAT_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FLAT = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  state_t                 state_q;
  logic [PHASE_W-1:0]     phase_q;
  logic [SIZE_ENERGY-1:0] acc_q;
  logic [SIZE_TIME-1:0]   cnt_q;
  logic                   armed_q;
  logic [SIZE_ENERGY-1:0] energy_q;
  logic                   energy_valid_q;
  logic [SIZE_TIME-1:0]   timestamp_q;

  logic                   at_or_below;
  logic [SIZE_ENERGY-1:0] sample_ext;
  logic [SIZE_ENERGY-1:0] acc_d;
  logic [SIZE_TIME-1:0]   cnt_d;
  logic [PHASE_W-1:0]     phase_inc;
  logic                   pileup_hit;

  assign at_or_below = $signed(data_in_i) <= $signed(threshold_i);
  assign sample_ext  = {{(SIZE_ENERGY - SIZE_DATA){data_in_i[SIZE_DATA-1]}}, data_in_i};
  assign acc_d       = acc_q + sample_ext;
  assign cnt_d       = cnt_q + SIZE_TIME'(1);
  assign phase_inc   = phase_q + PHASE_W'(1);

`ifdef TRAPEZ_PILEUP_REJECT_EN
  logic [15:0] pileup_q;

  assign pileup_hit = data_in_valid_i && at_or_below &&
                      ((state_q == ST_RISE) || (state_q == ST_FLAT));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pileup_q <= 16'd0;
    end else if (pileup_hit && (pileup_q != 16'hFFFF)) begin
      pileup_q <= pileup_q + 16'd1;
    end
  end

  assign pileup_count_o = pileup_q;
`else
  assign pileup_hit     = 1'b0;
  assign pileup_count_o = 16'd0;
`endif

  // Main event FSM with all datapath registers. Nothing moves without a valid
  // sample, so gaps in data_in_valid_i are invisible to the result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      armed_q        <= 1'b0;
      energy_q       <= '0;
      energy_valid_q <= 1'b0;
      timestamp_q    <= '0;
    end else begin
      energy_valid_q <= 1'b0;
      if (data_in_valid_i) begin
        cnt_q   <= cnt_d;
        // Re-arm only after seeing the input at or below threshold; this
        // keeps an input that is already high after reset from triggering.
        armed_q <= at_or_below;
        case (state_q)
          ST_IDLE: begin
            if (!at_or_below && armed_q) begin
              timestamp_q <= cnt_q;
              phase_q     <= '0;
              acc_q       <= '0;
              state_q     <= (RISE_TIME == 0) ? ST_FLAT : ST_RISE;
            end
          end
          ST_RISE: begin
            if (pileup_hit) begin
              state_q <= ST_IDLE;
            end else if (phase_q == RISE_LAST) begin
              phase_q <= '0;
              acc_q   <= '0;
              state_q <= ST_FLAT;
            end else begin
              phase_q <= phase_inc;
            end
          end
          ST_FLAT: begin
            if (pileup_hit) begin
              state_q <= ST_IDLE;
            end else if (phase_q == FLAT_LAST) begin
              // Final sum goes straight to the output register.
              energy_q       <= acc_d;
              energy_valid_q <= 1'b1;
              acc_q          <= acc_d;
              state_q        <= ST_FALL;
            end else begin
              acc_q   <= acc_d;
              phase_q <= phase_inc;
            end
          end
          ST_FALL: begin
            if (at_or_below) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign energy_o       = energy_q;
  assign energy_valid_o = energy_valid_q;
  assign timestamp_o    = timestamp_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trapez_energy_picker.sv
// tb/tb_trapez_energy_picker.sv - self-checking bench for trapez_energy_picker

module tb_trapez_energy_picker;

  localparam int SD = 26;
  localparam int K  = 25;
  localparam int L  = 20;
  localparam int SE = SD + 8;
  localparam int ST = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [SD-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic [SD-1:0] threshold = '0;
  logic [SE-1:0] energy;
  logic          energy_valid;
  logic [ST-1:0] timestamp;
  logic          busy;
  logic [15:0]   pileup_count;

  trapez_energy_picker dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .data_in_i       (data_in),
    .data_in_valid_i (data_in_valid),
    .threshold_i     (threshold),
    .energy_o        (energy),
    .energy_valid_o  (energy_valid),
    .timestamp_o     (timestamp),
    .busy_o          (busy),
    .pileup_count_o  (pileup_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: event tracked by trigger index, sums by index range.
  int     m_cnt;
  bit     m_armed;
  bit     m_in_evt;
  bit     m_fall;
  int     m_trig;
  longint m_acc;
  longint m_energy;
  int     m_ts;
  bit     m_ev;
  int     m_pile;

  // Observed events.
  int     n_pulses;
  longint last_energy;
  int     last_ts;
  int     pulse_sidx;
  int     tb_sidx;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_armed = 0; m_in_evt = 0; m_fall = 0; m_trig = 0;
    m_acc = 0; m_energy = 0; m_ts = 0; m_ev = 0; m_pile = 0;
    n_pulses = 0; last_energy = 0; last_ts = 0; pulse_sidx = -1; tb_sidx = 0;
  endtask

  task automatic model_sample(input int x, input int t);
    bit le;
    bit abort;
    int i;
    le    = (x <= t);
    i     = m_cnt;
    abort = 1'b0;
`ifdef TRAPEZ_PILEUP_REJECT_EN
    abort = le;
`endif
    if (m_in_evt) begin
      if (abort) begin
        m_in_evt = 0;
        if (m_pile < 65535) m_pile++;
      end else begin
        if (i > m_trig + K) m_acc += x;
        if (i == m_trig + K + L) begin
          m_energy = m_acc;
          m_ev     = 1;
          m_in_evt = 0;
          m_fall   = 1;
        end
      end
    end else if (m_fall) begin
      if (le) m_fall = 0;
    end else if (!le && m_armed) begin
      m_in_evt = 1;
      m_trig   = i;
      m_ts     = i % 65536;
      m_acc    = 0;
    end
    m_armed = le;
    m_cnt++;
  endtask

  task automatic compare_all();
    check("energy_valid", {63'd0, energy_valid}, {63'd0, m_ev});
    check("busy", {63'd0, busy}, {63'd0, (m_in_evt || m_fall)});
    check("energy", 64'($signed(energy)), m_energy);
    check("timestamp", {48'd0, timestamp}, 64'(m_ts));
    check("pileup_count", {48'd0, pileup_count}, 64'(m_pile));
  endtask

  task automatic step(input bit v, input int x, input int t);
    data_in_valid = v;
    data_in       = SD'(x);
    threshold     = SD'(t);
    @(posedge clk);
    m_ev = 0;
    if (v) begin
      model_sample(x, t);
      tb_sidx++;
    end
    #1;
    compare_all();
    if (energy_valid === 1'b1) begin
      n_pulses++;
      last_energy = 64'($signed(energy));
      last_ts     = int'(timestamp);
      pulse_sidx  = tb_sidx - 1;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    data_in_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic run(input int n, input int x, input int t, input bit toggle);
    for (int j = 0; j < n; j++) begin
      if (toggle) step(1'b0, x, t);
      step(1'b1, x, t);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Basic pulse, continuous valid.
    run(10, 0, 100, 0);
    run(60, 1000, 100, 0);
    step(1'b1, 0, 100);
    check("t1_busy_after_drop", {63'd0, busy}, 64'd0);
    run(5, 0, 100, 0);
    check("t1_pulses", 64'(n_pulses), 64'd1);
    check("t1_energy", last_energy, 64'sd20000);
    check("t1_ts", 64'(last_ts), 64'd10);
    check("t1_pulse_idx", 64'(pulse_sidx), 64'd55);

    // Same pulse with valid gaps.
    do_reset();
    run(10, 0, 100, 1);
    run(60, 1000, 100, 1);
    run(6, 0, 100, 1);
    check("t2_pulses", 64'(n_pulses), 64'd1);
    check("t2_energy", last_energy, 64'sd20000);
    check("t2_ts", 64'(last_ts), 64'd10);

    // High input from reset: must not trigger until it drops.
    do_reset();
    run(20, 500, 100, 0);
    check("t3_no_early_trigger", {63'd0, busy}, 64'd0);
    run(5, 0, 100, 0);
    run(60, 500, 100, 0);
    run(5, 0, 100, 0);
    check("t3_pulses", 64'(n_pulses), 64'd1);
    check("t3_energy", last_energy, 64'sd10000);
    check("t3_ts", 64'(last_ts), 64'd25);

    // Signed accumulation below zero threshold.
    do_reset();
    run(5, -1000, -500, 0);
    for (int j = 0; j < 60; j++) step(1'b1, (j % 2 == 0) ? -300 : 300, -500);
    run(5, -1000, -500, 0);
    check("t4_alt_pulses", 64'(n_pulses), 64'd1);
    check("t4_alt_energy", last_energy, 64'sd0);
    run(60, -300, -500, 0);
    run(5, -1000, -500, 0);
    check("t4_neg_pulses", 64'(n_pulses), 64'd2);
    check("t4_neg_energy", last_energy, -64'sd6000);

    // Reset in the middle of the flat top.
    do_reset();
    run(10, 0, 100, 0);
    run(1 + K + 5, 1000, 100, 0);
    do_reset();
    check("t5_energy_cleared", 64'($signed(energy)), 64'sd0);
    check("t5_busy_cleared", {63'd0, busy}, 64'd0);
    run(3, 1000, 100, 0);
    run(10, 0, 100, 0);
    run(60, 1000, 100, 0);
    run(5, 0, 100, 0);
    check("t5_pulses", 64'(n_pulses), 64'd1);
    check("t5_energy", last_energy, 64'sd20000);
    check("t5_ts", 64'(last_ts), 64'd13);

    // Dip during rise.
    do_reset();
    run(10, 0, 100, 0);
    run(10, 1000, 100, 0);
    step(1'b1, 50, 100);
    run(60, 1000, 100, 0);
    run(5, 0, 100, 0);
    check("t6_pulses", 64'(n_pulses), 64'd1);
    check("t6_energy", last_energy, 64'sd20000);
`ifdef TRAPEZ_PILEUP_REJECT_EN
    check("t6_pileups", {48'd0, pileup_count}, 64'd1);
    check("t6_ts", 64'(last_ts), 64'd21);
`else
    check("t6_pileups", {48'd0, pileup_count}, 64'd0);
    check("t6_ts", 64'(last_ts), 64'd10);
`endif

    // Randomized pulses, gaps and dips against the model.
    do_reset();
    for (int p = 0; p < 12; p++) begin
      int t;
      int len;
      int amp;
      t   = int'($urandom_range(400)) - 200;
      amp = int'($urandom_range(50000, 1));
      for (int j = 0; j < int'($urandom_range(15, 3)); j++)
        step($urandom_range(3) != 0, t - int'($urandom_range(1000)), t);
      len = int'($urandom_range(70, 5));
      for (int j = 0; j < len; j++) begin
        int x;
        x = ($urandom_range(9) == 0) ? t - 10 : t + amp - int'($urandom_range(100));
        step($urandom_range(3) != 0, x, t);
      end
    end
    run(5, -100000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
